// File: rtl/win3x3_linebuf_pkg.sv
// Shared definitions for the 3x3 window generator and the pixel-counter stage:
// one-hot frame phase encodings and default geometry.
package win3x3_linebuf_pkg;

  localparam logic [3:0] ST_FILL   = 4'b0001;
  localparam logic [3:0] ST_STEADY = 4'b0010;
  localparam logic [3:0] ST_FLUSH  = 4'b0100;
  localparam logic [3:0] ST_DONE   = 4'b1000;

  localparam int IMG_W_DEFAULT = 1026;
  localparam int DW_DEFAULT    = 8;

endpackage

// File: rtl/win3x3_linebuf_line_delay.sv
// Circular line delay: on each enabled cycle it returns the word written DEPTH
// enables ago and stores the new word at the same address.
module win3x3_linebuf_line_delay #(
  parameter int DEPTH = 1026,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] ptr_q, ptr_d;

  // Storage has no reset; the FILL phase overwrites every entry before use.
  always_ff @(posedge clk) begin
    if (en_i) begin
      mem[ptr_q] <= din_i;
    end
  end

  assign dout_o = mem[ptr_q];

  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/win3x3_linebuf.sv
// 3x3 sliding-window generator: two line delays feed three 3-tap shift rows,
// presented as one window per accepted pixel on a valid/ready port.
module win3x3_linebuf
  import win3x3_linebuf_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEFAULT,
  parameter int DW    = DW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      state,
  input  logic [DW-1:0]   input_data,
  input  logic            input_valid,
  output logic            input_ready,
  output logic [9*DW-1:0] win_data,
  output logic            win_valid,
  input  logic            win_ready,
  output logic            win_ovf
);

  logic          adv;
  logic          emit;
  logic [DW-1:0] new_pix;
  logic [DW-1:0] line1_out, line0_out;
  logic [DW-1:0] row_in [3];
  logic [DW-1:0] tap_q [3][3];
  logic          win_valid_q, win_valid_d;
  logic          ovf_q, ovf_d;

  always_comb begin
    input_ready = 1'b0;
    adv         = 1'b0;
    emit        = 1'b0;
    new_pix     = input_data;
    case (state)
      ST_FILL: begin
        input_ready = 1'b1;
        adv         = input_valid;
      end
      ST_STEADY: begin
        input_ready = !win_valid_q || win_ready;
        adv         = input_valid && input_ready;
        emit        = adv;
      end
      ST_FLUSH: begin
        // Zero padding on the bottom/right edge; flushing never stalls.
        adv     = 1'b1;
        emit    = 1'b1;
        new_pix = '0;
      end
      default: ;
    endcase
  end

  win3x3_linebuf_line_delay #(.DEPTH(IMG_W), .DW(DW)) u_line1 (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (adv),
    .din_i (new_pix),
    .dout_o(line1_out)
  );

  win3x3_linebuf_line_delay #(.DEPTH(IMG_W), .DW(DW)) u_line0 (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (adv),
    .din_i (line1_out),
    .dout_o(line0_out)
  );

  assign row_in[0] = line0_out;
  assign row_in[1] = line1_out;
  assign row_in[2] = new_pix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          tap_q[r][c] <= '0;
        end
      end
    end else if (adv) begin
      for (int r = 0; r < 3; r++) begin
        tap_q[r][0] <= tap_q[r][1];
        tap_q[r][1] <= tap_q[r][2];
        tap_q[r][2] <= row_in[r];
      end
    end
  end

  always_comb begin
    win_valid_d = win_valid_q;
    ovf_d       = ovf_q;
    if (emit) begin
      win_valid_d = 1'b1;
    end else if (!adv && win_valid_q && win_ready) begin
      win_valid_d = 1'b0;
    end
    if (adv && state == ST_FLUSH && win_valid_q && !win_ready) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      win_valid_q <= win_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_pack
      assign win_data[DW*gi +: DW] = tap_q[gi/3][gi%3];
    end
  endgenerate

  assign win_valid = win_valid_q;
  assign win_ovf   = ovf_q;

endmodule

// File: tb/tb_win3x3_linebuf.sv
// Directed bench for win3x3_linebuf with IMG_W=8: fill, steady streaming with
// backpressure, flush zero padding, overflow flag and asynchronous reset.
module tb_win3x3_linebuf;

  localparam int IMG_W = 8;
  localparam int DW    = 8;
  localparam logic [3:0] S_FILL   = 4'b0001;
  localparam logic [3:0] S_STEADY = 4'b0010;
  localparam logic [3:0] S_FLUSH  = 4'b0100;
  localparam logic [3:0] S_DONE   = 4'b1000;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      state;
  logic [DW-1:0]   input_data;
  logic            input_valid;
  logic            input_ready;
  logic [9*DW-1:0] win_data;
  logic            win_valid;
  logic            win_ready;
  logic            win_ovf;

  int n_cmp = 0;
  int n_err = 0;

  win3x3_linebuf #(.IMG_W(IMG_W), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .state      (state),
    .input_data (input_data),
    .input_valid(input_valid),
    .input_ready(input_ready),
    .win_data   (win_data),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_ovf    (win_ovf)
  );

  always #5 clk = ~clk;

  // Expected window once stream position p has been shifted in; stream
  // positions beyond last_pix are the zero padding injected by FLUSH.
  function automatic logic [9*DW-1:0] exp_win(input int p, input int last_pix);
    logic [9*DW-1:0] w;
    int q;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        q = p - (2 - r) * IMG_W - (2 - c);
        if (q >= 1 && q <= last_pix) w[DW*(r*3+c) +: DW] = DW'(q);
      end
    end
    return w;
  endfunction

  task automatic check(input string tag, input logic [9*DW-1:0] obs, input logic [9*DW-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; state = S_FILL; input_data = '0; input_valid = 1'b0; win_ready = 1'b0;

    // 1. Reset values and combinational ready decode
    #1;
    check("rst_win_valid", {71'd0, win_valid}, 72'd0);
    check("rst_win_ovf", {71'd0, win_ovf}, 72'd0);
    check("rst_win_data", win_data, 72'd0);
    check("rst_ready_fill", {71'd0, input_ready}, 72'd1);
    state = S_DONE;
    #1;
    check("rst_ready_done", {71'd0, input_ready}, 72'd0);
    state = S_FILL;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 2. FILL pixels 1..19, then STEADY pixel 20 yields the first window
    for (int p = 1; p <= 19; p++) begin
      input_valid = 1'b1; input_data = DW'(p);
      #1;
      check($sformatf("fill_ready_%0d", p), {71'd0, input_ready}, 72'd1);
      tick();
      check($sformatf("fill_valid_%0d", p), {71'd0, win_valid}, 72'd0);
    end
    state = S_STEADY; input_data = DW'(20);
    tick();
    check("first_valid", {71'd0, win_valid}, 72'd1);
    check("first_win_p20", win_data, exp_win(20, 255));

    // 3. Backpressure holds the window and blocks input for 5 cycles
    input_data = DW'(21);
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp_ready_%0d", k), {71'd0, input_ready}, 72'd0);
      tick();
      check($sformatf("bp_hold_%0d", k), win_data, exp_win(20, 255));
      check($sformatf("bp_valid_%0d", k), {71'd0, win_valid}, 72'd1);
    end
    win_ready = 1'b1;
    #1;
    check("bp_release_ready", {71'd0, input_ready}, 72'd1);
    tick();
    check("win_p21", win_data, exp_win(21, 255));

    // 4. Continuous streaming, one window per cycle, line pointer wraps
    for (int p = 22; p <= 37; p++) begin
      input_data = DW'(p);
      #1;
      check($sformatf("st_ready_%0d", p), {71'd0, input_ready}, 72'd1);
      tick();
      check($sformatf("st_valid_%0d", p), {71'd0, win_valid}, 72'd1);
      check($sformatf("st_win_%0d", p), win_data, exp_win(p, 255));
    end

    // 5. FLUSH after last pixel 37: zero padding walks in, all-zero by cycle 19
    input_valid = 1'b0; state = S_FLUSH;
    #1;
    check("flush_ready", {71'd0, input_ready}, 72'd0);
    for (int k = 1; k <= 19; k++) begin
      tick();
      check($sformatf("fl_valid_%0d", k), {71'd0, win_valid}, 72'd1);
      check($sformatf("fl_win_%0d", k), win_data, exp_win(37 + k, 37));
    end
    check("fl_all_zero", win_data, 72'd0);
    check("fl_ovf_clear", {71'd0, win_ovf}, 72'd0);

    // 6. Unaccepted windows during FLUSH set the sticky overflow flag
    win_ready = 1'b0;
    tick();
    tick();
    check("ovf_set", {71'd0, win_ovf}, 72'd1);
    check("ovf_valid", {71'd0, win_valid}, 72'd1);
    win_ready = 1'b1; state = S_DONE;
    #1;
    check("done_ready", {71'd0, input_ready}, 72'd0);
    tick();
    check("done_accept", {71'd0, win_valid}, 72'd0);
    check("ovf_sticky", {71'd0, win_ovf}, 72'd1);

    // Asynchronous reset in the middle of STEADY
    state = S_STEADY; win_ready = 1'b0; input_valid = 1'b1; input_data = DW'(55);
    tick();
    check("pre_rst_valid", {71'd0, win_valid}, 72'd1);
    input_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {71'd0, win_valid}, 72'd0);
    check("arst_ovf", {71'd0, win_ovf}, 72'd0);
    check("arst_data", win_data, 72'd0);
    tick();
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
